// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access pipeline stage.
// Issues loads/stores over a valid/ready request + valid response handshake,
// aligns store lanes, extends load data and stalls the pipe until completion.

package mem_stage_pkg;

   typedef struct packed {
      logic        RegWrite;
      logic [1:0]  ResultSrc;
      logic        MemWrite;
      logic [2:0]  funct3;
      logic [31:0] ALUResult;
      logic [31:0] WriteData;
      logic [31:0] PCPlus4;
      logic [4:0]  Rd;
      logic [31:0] ImmExt;
   } exmem_t;

   typedef struct packed {
      logic        RegWrite;
      logic [1:0]  ResultSrc;
      logic [31:0] ALUResult;
      logic [31:0] ReadData;
      logic [31:0] PCPlus4;
      logic [4:0]  Rd;
      logic [31:0] ImmExt;
   } memwb_t;

endpackage

module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  exmem_t      inputs,
   output memwb_t      outputs,
   output logic        StallM,
   output logic        MisalignM,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_rsp_valid,
   input  logic [31:0] dmem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t      state;
   logic [1:0]  off_q;
   logic [2:0]  f3_q;
   logic [31:0] read_data_q;

   logic        is_store;
   logic        is_load;
   logic        mem_op;
   logic        f3_ok;
   logic        align_ok;
   logic        legal;
   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   // Classify the incoming op and decide whether the access is legal
   always_comb begin
      is_store = inputs.MemWrite;
      is_load  = ~inputs.MemWrite & (inputs.ResultSrc == 2'b01);
      mem_op   = is_store | is_load;
      f3_ok    = 1'b0;
      case (inputs.funct3)
         3'b000, 3'b001, 3'b010: f3_ok = mem_op;
         3'b100, 3'b101:         f3_ok = is_load;
         default:                f3_ok = 1'b0;
      endcase
      case (inputs.funct3[1:0])
         2'b01:   align_ok = ~inputs.ALUResult[0];
         2'b10:   align_ok = (inputs.ALUResult[1:0] == 2'b00);
         default: align_ok = 1'b1;
      endcase
      legal = f3_ok & align_ok;
   end

   // Store byte-lane placement: data replicated, strobes pick the lanes
   always_comb begin
      case (inputs.funct3[1:0])
         2'b00: begin
            st_wstrb = 4'b0001 << inputs.ALUResult[1:0];
            st_wdata = {4{inputs.WriteData[7:0]}};
         end
         2'b01: begin
            st_wstrb = inputs.ALUResult[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{inputs.WriteData[15:0]}};
         end
         default: begin
            st_wstrb = 4'b1111;
            st_wdata = inputs.WriteData;
         end
      endcase
   end

   // Load extraction from the offset and funct3 captured at issue
   always_comb begin
      case (off_q)
         2'b00:   ld_byte = dmem_rdata[7:0];
         2'b01:   ld_byte = dmem_rdata[15:8];
         2'b10:   ld_byte = dmem_rdata[23:16];
         default: ld_byte = dmem_rdata[31:24];
      endcase
      ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (f3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {24'h000000, ld_byte};
         3'b101:  ld_ext = {16'h0000, ld_half};
         default: ld_ext = dmem_rdata;
      endcase
   end

   // Stall and fault flags; both held low while reset is asserted
   always_comb begin
      StallM    = ~reset & (((state == S_IDLE) & mem_op & legal) |
                            (state == S_REQ) | (state == S_WAIT));
      MisalignM = ~reset & (state == S_IDLE) & mem_op & ~legal;
   end

   // MEM/WB bundle: pass-through except read data and gated RegWrite
   always_comb begin
      outputs.RegWrite  = inputs.RegWrite & ~StallM & ~MisalignM;
      outputs.ResultSrc = inputs.ResultSrc;
      outputs.ALUResult = inputs.ALUResult;
      outputs.ReadData  = read_data_q;
      outputs.PCPlus4   = inputs.PCPlus4;
      outputs.Rd        = inputs.Rd;
      outputs.ImmExt    = inputs.ImmExt;
   end

   // Access FSM with registered request channel and load data
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         dmem_req_valid <= 1'b0;
         dmem_we        <= 1'b0;
         dmem_addr      <= '0;
         dmem_wdata     <= '0;
         dmem_wstrb     <= '0;
         read_data_q    <= '0;
         off_q          <= '0;
         f3_q           <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (mem_op && legal) begin
                  dmem_addr      <= {inputs.ALUResult[31:2], 2'b00};
                  dmem_we        <= is_store;
                  dmem_wdata     <= is_store ? st_wdata : '0;
                  dmem_wstrb     <= is_store ? st_wstrb : '0;
                  off_q          <= inputs.ALUResult[1:0];
                  f3_q           <= inputs.funct3;
                  dmem_req_valid <= 1'b1;
                  state          <= S_REQ;
               end
            end
            S_REQ: begin
               if (dmem_req_ready) begin
                  dmem_req_valid <= 1'b0;
                  state          <= dmem_we ? S_DONE : S_WAIT;
               end
            end
            S_WAIT: begin
               if (dmem_rsp_valid) begin
                  read_data_q <= ld_ext;
                  state       <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed-vector bench for mem_stage with a small responder.

module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   exmem_t      in_bus;
   memwb_t      out_bus;
   logic        stall_m;
   logic        misalign_m;
   logic        req_valid;
   logic        req_ready;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        rsp_valid;
   logic [31:0] rdata;

   int checks   = 0;
   int failures = 0;

   int          n_stall;
   int          n_rw;
   int          req_cycles;
   int          first_req_c;
   bit          unstable;
   logic [31:0] f_addr;
   logic [31:0] f_wdata;
   logic [3:0]  f_wstrb;
   logic        f_we;
   logic [31:0] last_rd;
   logic        last_rw;

   mem_stage dut (
      .clk            (clk),
      .reset          (reset),
      .inputs         (in_bus),
      .outputs        (out_bus),
      .StallM         (stall_m),
      .MisalignM      (misalign_m),
      .dmem_req_valid (req_valid),
      .dmem_req_ready (req_ready),
      .dmem_we        (we),
      .dmem_addr      (addr),
      .dmem_wdata     (wdata),
      .dmem_wstrb     (wstrb),
      .dmem_rsp_valid (rsp_valid),
      .dmem_rdata     (rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic exmem_t mk(input logic rw, input logic [1:0] rs, input logic mw,
                                 input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd);
      exmem_t op;
      op           = '0;
      op.RegWrite  = rw;
      op.ResultSrc = rs;
      op.MemWrite  = mw;
      op.funct3    = f3;
      op.ALUResult = a;
      op.WriteData = wd;
      op.PCPlus4   = 32'h0000_1004;
      op.Rd        = 5'd7;
      op.ImmExt    = 32'h0000_0010;
      return op;
   endfunction

   function automatic exmem_t nop();
      return mk(1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0);
   endfunction

   // Present op (called at posedge+1) and act as memory until StallM drops.
   task automatic run_op(input exmem_t op, input int rdy_wait, input int rsp_wait,
                         input logic [31:0] rsp_data, input bit junk);
      int  since_acc = 0;
      bit  accepted  = 0;
      bit  done      = 0;
      in_bus      = op;
      n_stall     = 0;
      n_rw        = 0;
      req_cycles  = 0;
      first_req_c = -1;
      unstable    = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         req_ready = 1'b0;
         rsp_valid = 1'b0;
         rdata     = 32'hBAD0_BAD0;
         if (stall_m) n_stall++;
         if (out_bus.RegWrite) n_rw++;
         if (req_valid) begin
            if (first_req_c < 0) begin
               first_req_c = c;
               f_addr  = addr;
               f_wdata = wdata;
               f_wstrb = wstrb;
               f_we    = we;
            end else if (addr !== f_addr || wdata !== f_wdata ||
                         wstrb !== f_wstrb || we !== f_we) begin
               unstable = 1;
            end
            if (req_cycles >= rdy_wait) begin
               req_ready = 1'b1;
               accepted  = 1;
            end
            req_cycles++;
            if (junk) rsp_valid = 1'b1;
         end else if (accepted) begin
            since_acc++;
            if (since_acc == rsp_wait) begin
               rsp_valid = 1'b1;
               rdata     = rsp_data;
            end
         end else if (req_cycles > 0) begin
            unstable = 1;
         end
         if (!stall_m) begin
            done    = 1;
            last_rd = out_bus.ReadData;
            last_rw = out_bus.RegWrite;
         end
         @(posedge clk);
         #1;
      end
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      in_bus    = nop();
      if (!done) check("op_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      reset     = 1'b1;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rdata     = '0;
      in_bus    = mk(1'b1, 2'b01, 1'b0, 3'b010, 32'h100, 32'h0);

      // Reset state, with a legal load present on the inputs
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_stall",    32'(stall_m),    32'd0);
      check("rst_misalign", 32'(misalign_m), 32'd0);
      check("rst_req",      32'(req_valid),  32'd0);
      check("rst_we",       32'(we),         32'd0);
      check("rst_addr",     addr,            32'h0);
      check("rst_wdata",    wdata,           32'h0);
      check("rst_wstrb",    32'(wstrb),      32'h0);
      check("rst_rdata",    out_bus.ReadData, 32'h0);
      @(posedge clk); #1;
      reset  = 1'b0;
      in_bus = nop();
      @(posedge clk); #1;

      // Non-memory op: no stall, pass-through
      in_bus = mk(1'b1, 2'b00, 1'b0, 3'b000, 32'h1234_5678, 32'h0);
      @(negedge clk);
      check("alu_stall", 32'(stall_m),          32'd0);
      check("alu_rw",    32'(out_bus.RegWrite), 32'd1);
      check("alu_res",   out_bus.ALUResult,     32'h1234_5678);
      check("alu_pc4",   out_bus.PCPlus4,       32'h0000_1004);
      @(posedge clk); #1;

      // SW 0x100
      run_op(mk(1'b0, 2'b00, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF), 0, 0, 32'h0, 0);
      check("sw_req_cycle", 32'(first_req_c), 32'd1);
      check("sw_addr",      f_addr,           32'h100);
      check("sw_wstrb",     32'(f_wstrb),     32'hF);
      check("sw_we",        32'(f_we),        32'd1);
      check("sw_wdata",     f_wdata,          32'hDEAD_BEEF);
      check("sw_stall",     32'(n_stall),     32'd2);
      check("sw_rw",        32'(n_rw),        32'd0);

      // SB 0x103
      run_op(mk(1'b0, 2'b00, 1'b1, 3'b000, 32'h103, 32'h0000_00A5), 0, 0, 32'h0, 0);
      check("sb_addr",  f_addr,       32'h100);
      check("sb_wstrb", 32'(f_wstrb), 32'h8);
      check("sb_wdata", f_wdata,      32'hA5A5_A5A5);
      check("sb_stall", 32'(n_stall), 32'd2);

      // SH 0x102
      run_op(mk(1'b0, 2'b00, 1'b1, 3'b001, 32'h102, 32'h1234_BEEF), 0, 0, 32'h0, 0);
      check("sh_wstrb", 32'(f_wstrb), 32'hC);
      check("sh_wdata", f_wdata,      32'hBEEF_BEEF);

      // LB 0x101, junk response offered during the request phase
      run_op(mk(1'b1, 2'b01, 1'b0, 3'b000, 32'h101, 32'h0), 0, 1, 32'h12AB_34CD, 1);
      check("lb_addr",  f_addr,       32'h100);
      check("lb_we",    32'(f_we),    32'd0);
      check("lb_wstrb", 32'(f_wstrb), 32'h0);
      check("lb_data",  last_rd,      32'h0000_0034);
      check("lb_stall", 32'(n_stall), 32'd3);
      check("lb_rw",    32'(last_rw), 32'd1);

      // LB / LBU sign vs zero extension
      run_op(mk(1'b1, 2'b01, 1'b0, 3'b000, 32'h101, 32'h0), 0, 1, 32'h12AB_80CD, 0);
      check("lb_sext", last_rd, 32'hFFFF_FF80);
      run_op(mk(1'b1, 2'b01, 1'b0, 3'b100, 32'h101, 32'h0), 0, 1, 32'h12AB_80CD, 0);
      check("lbu_zext", last_rd, 32'h0000_0080);

      // LH / LHU upper half
      run_op(mk(1'b1, 2'b01, 1'b0, 3'b001, 32'h102, 32'h0), 0, 1, 32'h8001_7777, 0);
      check("lh_sext", last_rd, 32'hFFFF_8001);
      run_op(mk(1'b1, 2'b01, 1'b0, 3'b101, 32'h102, 32'h0), 0, 1, 32'h8001_7777, 0);
      check("lhu_zext", last_rd, 32'h0000_8001);

      // LW 0x200, ready low 3 cycles, response 2 cycles after accept
      run_op(mk(1'b1, 2'b01, 1'b0, 3'b010, 32'h200, 32'h0), 3, 2, 32'hCAFE_F00D, 0);
      check("lw_addr",     f_addr,          32'h200);
      check("lw_req_cyc",  32'(req_cycles), 32'd4);
      check("lw_unstable", 32'(unstable),   32'd0);
      check("lw_stall",    32'(n_stall),    32'd7);
      check("lw_rw",       32'(n_rw),       32'd1);
      check("lw_data",     last_rd,         32'hCAFE_F00D);

      // Misaligned LW 0x202
      in_bus = mk(1'b1, 2'b01, 1'b0, 3'b010, 32'h202, 32'h0);
      @(negedge clk);
      check("mis_flag",  32'(misalign_m),       32'd1);
      check("mis_stall", 32'(stall_m),          32'd0);
      check("mis_req",   32'(req_valid),        32'd0);
      check("mis_rw",    32'(out_bus.RegWrite), 32'd0);
      @(posedge clk); #1;
      in_bus = nop();
      @(negedge clk);
      check("mis_pulse", 32'(misalign_m), 32'd0);
      check("mis_noreq", 32'(req_valid),  32'd0);
      @(posedge clk); #1;

      // Store with illegal funct3 (aligned address)
      in_bus = mk(1'b0, 2'b00, 1'b1, 3'b100, 32'h100, 32'h0);
      @(negedge clk);
      check("ill_flag",  32'(misalign_m), 32'd1);
      check("ill_stall", 32'(stall_m),    32'd0);
      @(posedge clk); #1;
      in_bus = nop();

      // Reset while in WAIT, late response afterwards
      in_bus = mk(1'b1, 2'b01, 1'b0, 3'b010, 32'h300, 32'h0);
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check("rw_req", 32'(req_valid), 32'd1);
      req_ready = 1'b1;
      @(posedge clk); #1;
      req_ready = 1'b0;
      @(negedge clk);
      check("rw_wait_stall", 32'(stall_m), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset     = 1'b0;
      in_bus    = nop();
      rsp_valid = 1'b1;
      rdata     = 32'hFFFF_FFFF;
      @(negedge clk);
      check("rw_stall", 32'(stall_m),          32'd0);
      check("rw_reqv",  32'(req_valid),        32'd0);
      check("rw_rdata", out_bus.ReadData,      32'h0);
      check("rw_rw",    32'(out_bus.RegWrite), 32'd0);
      @(posedge clk); #1;
      rsp_valid = 1'b0;
      @(negedge clk);
      check("rw_drop", out_bus.ReadData, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the RV32I core. It consumes the EX/MEM bundle (`exmem_t`) produced by the execute stage and issues loads and stores to the data memory over a valid/ready request and valid response handshake. It aligns store data into byte lanes and sign- or zero-extends load data. It holds the pipeline with `StallM` until each access completes, and it presents the `memwb_t` bundle to the MEM/WB register.

## Interface
Parameters:
- none. The stage is fixed at 32 bits for RV32I.

Ports:
- `clk`  in  1  the single clock.
- `reset`  in  1  synchronous, active-high reset.
- `inputs`  in  `exmem_t`  EX/MEM register contents. Fields used: `RegWrite`, `ResultSrc[1:0]` (01 = load), `MemWrite`, `funct3[2:0]`, `ALUResult` (address), `WriteData`, `PCPlus4`, `Rd`, `ImmExt`.
- `outputs`  out  `memwb_t`  bundle to the MEM/WB register: `RegWrite`, `ResultSrc`, `ALUResult`, `ReadData`, `PCPlus4`, `Rd`, `ImmExt`.
- `StallM`  out  1  to the hazard unit; freezes PC, IF/ID, ID/EX and EX/MEM.
- `MisalignM`  out  1  one-cycle fault pulse for a misaligned or illegal-`funct3` access.
- `dmem_req_valid`  out  1  request valid (registered).
- `dmem_req_ready`  in  1  memory accepts the request.
- `dmem_we`  out  1  1 = store, 0 = load.
- `dmem_addr`  out  32  word-aligned address: `{ALUResult[31:2], 2'b00}`.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_wstrb`  out  4  byte enables; 0000 for loads.
- `dmem_rsp_valid`  in  1  load data valid.
- `dmem_rdata`  in  32  load data word.

## Operation
- A memory op is present when `MemWrite=1` or `ResultSrc=01`. `MemWrite` takes priority if both are set.
- FSM states and transitions:
  - IDLE:
    - If a memory op is present and legal: register `dmem_addr`, `dmem_we`, `dmem_wdata`, `dmem_wstrb` and the offset `ALUResult[1:0]`, then go to REQ.
    - Otherwise stay in IDLE.
  - REQ: `dmem_req_valid=1`. Address, data and strobes stay stable until `dmem_req_ready=1`. On acceptance a store goes to DONE and a load goes to WAIT.
  - WAIT: on `dmem_rsp_valid=1`, the extended load data is captured into the `ReadData` register and the FSM goes to DONE.
  - DONE: the access is complete. Go to IDLE.
- `StallM = 1` when:
  - in IDLE with a legal memory op present, or
  - in REQ, or
  - in WAIT.
- `StallM = 0` in DONE and for non-memory ops.
- Legality of an access:
  - Halfword (`funct3[1:0]=01`) needs `addr[0]=0`.
  - Word (`010`) needs `addr[1:0]=00`.
  - Loads allow `funct3` 000, 001, 010, 100, 101.
  - Stores allow `funct3` 000, 001, 010.
  - Any other case is illegal.
- Illegal access while in IDLE:
  - `MisalignM=1` for that cycle.
  - No request is issued and `StallM=0`.
  - `outputs.RegWrite` is forced to 0.
- Store lane placement:
  - SB: `wstrb = 0001 << addr[1:0]`, `wdata = {4{WriteData[7:0]}}`.
  - SH: `wstrb = addr[1] ? 1100 : 0011`, `wdata = {2{WriteData[15:0]}}`.
  - SW: `wstrb = 1111`, `wdata = WriteData`.
- Load extraction uses the registered offset:
  - LB / LBU: sign- or zero-extend the selected byte.
  - LH / LHU: sign- or zero-extend the selected half.
  - LW: the whole word.
- `outputs` fields pass through combinationally from `inputs`, except:
  - `ReadData` comes from the register.
  - `RegWrite = inputs.RegWrite & ~StallM & ~MisalignM`.
- `dmem_rsp_valid` is ignored in IDLE, REQ and DONE.

## Timing
- Reset values:
  - State IDLE.
  - `dmem_req_valid`, `dmem_we` = 0.
  - `dmem_addr`, `dmem_wdata`, `ReadData` = 0.
  - `dmem_wstrb` = 0000.
  - `StallM`, `MisalignM` = 0. Both are forced to 0 while `reset=1`.
- Non-memory op: zero added latency; `StallM` stays 0.
- Store with immediate ready. Op arrives in cycle N:
  - N: IDLE, stall.
  - N+1: REQ, accepted.
  - N+2: DONE, no stall.
  - Total 3 cycles, `StallM` high for 2.
- Load with ready in N+1 and response in N+2:
  - N+3: DONE.
  - `ReadData` is valid from N+3.
  - `StallM` high for N..N+2.
- Each cycle of `dmem_req_ready=0` or `dmem_rsp_valid=0` adds one stall cycle. There is no timeout.
- A response arriving in the same cycle as acceptance does not complete the load; the response must come in WAIT.
- The upstream stages advance exactly when `StallM=0`. The op in DONE is therefore never reissued, and the next cycle presents a new instruction in IDLE.
- Reset mid-access (REQ or WAIT): next cycle is IDLE with `dmem_req_valid=0`. A late `dmem_rsp_valid` is dropped.

## Test plan
- SW at `addr=0x100`, `WriteData=0xDEADBEEF`, ready=1:
  - N+1: `req_valid=1`, `dmem_addr=0x100`, `wstrb=1111`, `we=1`.
  - `StallM` high for 2 cycles.
  - `RegWrite` out = 0.
- SB at `0x103`, `WriteData=0x000000A5`: `wstrb=1000`, `wdata=0xA5A5A5A5`. SH at `0x102`: `wstrb=1100`.
- LB at `0x101`, `rdata=0x12AB34CD`, rsp one cycle after accept: `ReadData=0x00000034`. With `rdata=0x12AB80CD`: LB gives `0xFFFFFF80`, LBU gives `0x00000080`.
- LW at `0x200`, ready held low 3 cycles, response 2 cycles after accept:
  - `req_valid`, `addr` stable throughout.
  - `StallM` high for exactly 7 cycles.
  - `RegWrite` out = 1 only in the DONE cycle.
- LW at `0x202`: `MisalignM=1` for one cycle, no request, `StallM=0`, `RegWrite` out = 0.
- Reset asserted in WAIT, then `rsp_valid=1` after reset: state is IDLE, `ReadData=0`, no stall, no spurious `RegWrite`.
